intersection_sequencer: RTL and testbench

INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

---
 rtl/intersection_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_intersection_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_sequencer.sv
// Two-road traffic-light sequencer with tick-based state timers, a pedestrian
// green-shortening request, and flashing-yellow night operation.
module intersection_sequencer #(
    parameter int unsigned T_GREEN   = 30,
    parameter int unsigned T_YELLOW  = 3,
    parameter int unsigned T_ALL_RED = 2,
    parameter int unsigned T_PED_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic       div_enable,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic [7:0] remaining
);

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_ALL_RED_1 = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_ALL_RED_2 = 3'd5,
        S_NIGHT     = 3'd6
    } state_t;

    localparam logic [7:0] DUR_GREEN   = 8'(T_GREEN - 1);
    localparam logic [7:0] DUR_YELLOW  = 8'(T_YELLOW - 1);
    localparam logic [7:0] DUR_ALL_RED = 8'(T_ALL_RED - 1);
    localparam logic [7:0] PED_LOAD    = 8'(T_PED_MIN - 1);

    // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk}
    localparam logic [6:0] LAMPS_ALL_RED = 7'b1001000;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       ped_pending_q, ped_pending_d;
    logic       ped_used_q, ped_used_d;
    logic       blink_q, blink_d;
    logic       night_req_q, night_req_d;
    logic [6:0] lamps_q;
    logic       adv;
    logic       expire;

    function automatic logic [6:0] decode_lamps(input state_t s, input logic b);
        logic [6:0] l;
        case (s)
            S_NS_GREEN:  l = 7'b0011000;
            S_NS_YELLOW: l = 7'b0101000;
            S_EW_GREEN:  l = 7'b1000011;
            S_EW_YELLOW: l = 7'b1000100;
            S_NIGHT:     l = {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
            default:     l = LAMPS_ALL_RED;
        endcase
        return l;
    endfunction

    assign adv    = enable & tick;
    assign expire = adv & (timer_q == '0);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        ped_pending_d = ped_pending_q | ped_req;
        ped_used_d    = ped_used_q;
        blink_d       = blink_q;
        night_req_d   = night_req_q;

        if (adv && timer_q != '0) begin
            timer_d = timer_q - 8'd1;
        end

        case (state_q)
            S_NS_GREEN: begin
                if (expire) begin
                    state_d     = S_NS_YELLOW;
                    timer_d     = DUR_YELLOW;
                    night_req_d = night_mode;
                // A fresh press is honoured on the same edge it is latched.
                end else if (enable && !ped_used_q && (ped_pending_q || ped_req)
                             && timer_q > PED_LOAD) begin
                    timer_d    = PED_LOAD;
                    ped_used_d = 1'b1;
                end
            end
            S_NS_YELLOW: begin
                if (expire) begin
                    state_d = S_ALL_RED_1;
                    timer_d = DUR_ALL_RED;
                end
            end
            S_ALL_RED_1: begin
                if (expire) begin
                    if (night_req_q) begin
                        state_d = S_NIGHT;
                        timer_d = '0;
                        blink_d = 1'b1;
                    end else begin
                        state_d       = S_EW_GREEN;
                        timer_d       = DUR_GREEN;
                        ped_pending_d = 1'b0;
                    end
                end
            end
            S_EW_GREEN: begin
                if (expire) begin
                    state_d     = S_EW_YELLOW;
                    timer_d     = DUR_YELLOW;
                    night_req_d = night_mode;
                end
            end
            S_EW_YELLOW: begin
                if (expire) begin
                    state_d = S_ALL_RED_2;
                    timer_d = DUR_ALL_RED;
                end
            end
            S_ALL_RED_2: begin
                if (expire) begin
                    if (night_req_q) begin
                        state_d = S_NIGHT;
                        timer_d = '0;
                        blink_d = 1'b1;
                    end else begin
                        state_d    = S_NS_GREEN;
                        timer_d    = DUR_GREEN;
                        ped_used_d = 1'b0;
                    end
                end
            end
            S_NIGHT: begin
                timer_d = '0;
                if (adv) begin
                    if (!night_mode) begin
                        state_d     = S_ALL_RED_2;
                        timer_d     = DUR_ALL_RED;
                        blink_d     = 1'b0;
                        night_req_d = 1'b0;
                    end else begin
                        blink_d = ~blink_q;
                    end
                end
            end
            default: begin
                state_d = S_ALL_RED_2;
                timer_d = DUR_ALL_RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_ALL_RED_2;
            timer_q       <= DUR_ALL_RED;
            ped_pending_q <= 1'b0;
            ped_used_q    <= 1'b0;
            blink_q       <= 1'b0;
            night_req_q   <= 1'b0;
            lamps_q       <= LAMPS_ALL_RED;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            ped_used_q    <= ped_used_d;
            blink_q       <= blink_d;
            night_req_q   <= night_req_d;
            lamps_q       <= decode_lamps(state_d, blink_d);
        end
    end

    assign div_enable = enable;
    assign phase      = state_q;
    assign remaining  = timer_q;
    assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk} = lamps_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer with short timings and a tick
// every fourth clock.
module tb_intersection_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic       night_mode = 1'b0;
    logic       ped_req = 1'b0;
    logic       div_enable;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk;
    logic [2:0] phase;
    logic [7:0] remaining;
    logic [6:0] lamps;

    int checks = 0;
    int failures = 0;

    intersection_sequencer #(
        .T_GREEN  (4),
        .T_YELLOW (2),
        .T_ALL_RED(1),
        .T_PED_MIN(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .enable    (enable),
        .night_mode(night_mode),
        .ped_req   (ped_req),
        .div_enable(div_enable),
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .ped_walk  (ped_walk),
        .phase     (phase),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

    // Expected lamps per state, {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}.
    function automatic logic [6:0] exp_lamps(input int p, input logic b);
        case (p)
            0:       return 7'b0011000;
            1:       return 7'b0101000;
            3:       return 7'b1000011;
            4:       return 7'b1000100;
            6:       return {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
            default: return 7'b1001000;
        endcase
    endfunction

    task automatic clk1(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic do_tick();
        repeat (3) clk1(1'b0);
        clk1(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) clk1(1'b1);
        checks++;
        if (phase !== 3'd5 || remaining !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got phase=%0d rem=%0d exp phase=5 rem=0", phase, remaining);
        end
        checks++;
        if (lamps !== 7'b1001000) begin
            failures++;
            $display("FAIL reset_lamps got=%b exp=1001000", lamps);
        end
        checks++;
        if (dut.ped_pending_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending got=%b exp=0", dut.ped_pending_q);
        end
        checks++;
        if (div_enable !== 1'b0) begin
            failures++;
            $display("FAIL div_enable_low got=%b exp=0", div_enable);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (div_enable !== 1'b1) begin
            failures++;
            $display("FAIL div_enable_high got=%b exp=1", div_enable);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal_cycle();
        int unsigned ph[15] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};
        int unsigned rm[15] = '{3, 2, 1, 0, 1, 0, 0, 3, 2, 1, 0, 1, 0, 0, 3};
        for (int i = 0; i < 15; i++) begin
            do_tick();
            checks++;
            if (phase !== 3'(ph[i]) || remaining !== 8'(rm[i])) begin
                failures++;
                $display("FAIL normal_step%0d got phase=%0d rem=%0d exp phase=%0d rem=%0d",
                         i, phase, remaining, ph[i], rm[i]);
            end
            checks++;
            if (lamps !== exp_lamps(int'(ph[i]), 1'b0)) begin
                failures++;
                $display("FAIL normal_lamps%0d got=%b exp=%b", i, lamps, exp_lamps(int'(ph[i]), 1'b0));
            end
        end
    endtask

    task automatic test_ped_shorten();
        int unsigned ph[6] = '{0, 1, 1, 2, 3, 3};
        int unsigned rm[6] = '{0, 1, 0, 0, 3, 2};
        logic        pd[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ped_req = 1'b1;
        clk1(1'b0);
        ped_req = 1'b0;
        checks++;
        if (phase !== 3'd0 || remaining !== 8'd1) begin
            failures++;
            $display("FAIL ped_shorten got phase=%0d rem=%0d exp phase=0 rem=1", phase, remaining);
        end
        for (int i = 0; i < 6; i++) begin
            do_tick();
            checks++;
            if (phase !== 3'(ph[i]) || remaining !== 8'(rm[i])) begin
                failures++;
                $display("FAIL ped_step%0d got phase=%0d rem=%0d exp phase=%0d rem=%0d",
                         i, phase, remaining, ph[i], rm[i]);
            end
            checks++;
            if (dut.ped_pending_q !== pd[i]) begin
                failures++;
                $display("FAIL ped_pending%0d got=%b exp=%b", i, dut.ped_pending_q, pd[i]);
            end
            checks++;
            if (lamps !== exp_lamps(int'(ph[i]), 1'b0)) begin
                failures++;
                $display("FAIL ped_lamps%0d got=%b exp=%b", i, lamps, exp_lamps(int'(ph[i]), 1'b0));
            end
        end
    endtask

    task automatic test_freeze();
        int unsigned ph[6] = '{3, 3, 4, 4, 5, 0};
        int unsigned rm[6] = '{1, 0, 1, 0, 0, 3};
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk1((i % 4) == 3);
            checks++;
            if (phase !== 3'd3 || remaining !== 8'd2 || lamps !== 7'b1000011 || div_enable !== 1'b0) begin
                failures++;
                $display("FAIL freeze_hold%0d got phase=%0d rem=%0d lamps=%b div=%b exp 3 2 1000011 0",
                         i, phase, remaining, lamps, div_enable);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_tick();
            checks++;
            if (phase !== 3'(ph[i]) || remaining !== 8'(rm[i])) begin
                failures++;
                $display("FAIL freeze_resume%0d got phase=%0d rem=%0d exp phase=%0d rem=%0d",
                         i, phase, remaining, ph[i], rm[i]);
            end
        end
    endtask

    task automatic test_night();
        int unsigned ph[11] = '{0, 0, 0, 1, 1, 2, 6, 6, 6, 5, 0};
        int unsigned rm[11] = '{2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3};
        logic        bl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        night_mode = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 9) night_mode = 1'b0;
            do_tick();
            checks++;
            if (phase !== 3'(ph[i]) || remaining !== 8'(rm[i])) begin
                failures++;
                $display("FAIL night_step%0d got phase=%0d rem=%0d exp phase=%0d rem=%0d",
                         i, phase, remaining, ph[i], rm[i]);
            end
            checks++;
            if (lamps !== exp_lamps(int'(ph[i]), bl[i])) begin
                failures++;
                $display("FAIL night_lamps%0d got=%b exp=%b", i, lamps, exp_lamps(int'(ph[i]), bl[i]));
            end
        end
    endtask

    task automatic test_night_reset();
        night_mode = 1'b1;
        repeat (7) do_tick();
        checks++;
        if (phase !== 3'd6 || lamps !== 7'b0100100) begin
            failures++;
            $display("FAIL nreset_pre got phase=%0d lamps=%b exp phase=6 lamps=0100100", phase, lamps);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (phase !== 3'd5 || remaining !== 8'd0 || lamps !== 7'b1001000) begin
            failures++;
            $display("FAIL nreset_async got phase=%0d rem=%0d lamps=%b exp 5 0 1001000",
                     phase, remaining, lamps);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        night_mode = 1'b0;
        checks++;
        if (dut.blink_q !== 1'b0 || phase !== 3'd5) begin
            failures++;
            $display("FAIL nreset_blink got blink=%b phase=%0d exp blink=0 phase=5", dut.blink_q, phase);
        end
        do_tick();
        checks++;
        if (phase !== 3'd0 || remaining !== 8'd3) begin
            failures++;
            $display("FAIL nreset_release got phase=%0d rem=%0d exp phase=0 rem=3", phase, remaining);
        end
    endtask

    task automatic test_ped_at_entry();
        repeat (6) do_tick();
        repeat (3) clk1(1'b0);
        ped_req = 1'b1;
        clk1(1'b1);
        ped_req = 1'b0;
        checks++;
        if (phase !== 3'd3 || remaining !== 8'd3 || dut.ped_pending_q !== 1'b0) begin
            failures++;
            $display("FAIL entry_clear got phase=%0d rem=%0d pend=%b exp 3 3 0",
                     phase, remaining, dut.ped_pending_q);
        end
        ped_req = 1'b1;
        clk1(1'b0);
        ped_req = 1'b0;
        checks++;
        if (dut.ped_pending_q !== 1'b1) begin
            failures++;
            $display("FAIL entry_repress got pend=%b exp=1", dut.ped_pending_q);
        end
        repeat (7) do_tick();
        checks++;
        if (phase !== 3'd0 || remaining !== 8'd3) begin
            failures++;
            $display("FAIL entry_ns got phase=%0d rem=%0d exp phase=0 rem=3", phase, remaining);
        end
        clk1(1'b0);
        checks++;
        if (remaining !== 8'd1) begin
            failures++;
            $display("FAIL entry_honoured got rem=%0d exp=1", remaining);
        end
        repeat (2) do_tick();
        checks++;
        if (phase !== 3'd1 || remaining !== 8'd1) begin
            failures++;
            $display("FAIL entry_yellow got phase=%0d rem=%0d exp phase=1 rem=1", phase, remaining);
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_shorten();
        test_freeze();
        test_night();
        test_night_reset();
        test_ped_at_entry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
